mod_reduct_gl_arb: RTL and testbench

- Shares one pipelined 64-bit Goldilocks modular reduction unit between N_REQ requesters.
- Arbitrates input products round-robin and drives the external reducer.
- Tracks each in-flight operation's requester ID through a tag pipe matched to the reducer latency.
- Steers each result into a per-requester output buffer; grants are credit-gated, so the stall-free reducer never overflows a buffer.

---
 rtl/mod_reduct_gl_arb.sv | 157 +++++++++++++++
 tb/tb_mod_reduct_gl_arb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduct_gl_arb.sv
// Round-robin, credit-gated front end sharing one Goldilocks reducer among N_REQ requesters.
// Define MOD_REDUCT_GL_ARB_CHECK_EN to enable the sticky err flag and simulation assertions.
module mod_reduct_gl_arb #(
    parameter int N_REQ     = 4,
    parameter int MOD_W     = 64,
    parameter int RED_LAT   = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         in_vld,
    output logic [N_REQ-1:0]         in_rdy,
    input  logic [N_REQ*2*MOD_W-1:0] in_data,
    output logic                     red_avail,
    output logic [2*MOD_W-1:0]       red_a,
    input  logic                     red_z_avail,
    input  logic [MOD_W-1:0]         red_z,
    output logic [N_REQ-1:0]         out_vld,
    input  logic [N_REQ-1:0]         out_rdy,
    output logic [N_REQ*MOD_W-1:0]   out_data,
    output logic                     err
);
    localparam int DW = 2 * MOD_W;
    localparam int IW = $clog2(N_REQ);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic [IW-1:0]              r_ptr;
    logic [RED_LAT:0]           r_tv;
    logic [RED_LAT:0][IW-1:0]   r_tid;

    logic [N_REQ-1:0] w_cok;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [N_REQ-1:0] w_wr;
    logic [N_REQ-1:0] w_pop;
    logic [IW-1:0]    w_gidx;
    logic [IW-1:0]    w_nxt;
    logic             w_any;
    logic [DW-1:0]    w_sel;

    function automatic logic [IW-1:0] f_rot(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    assign w_elig = in_vld & w_cok & {N_REQ{~rst}};
    assign w_pop  = out_vld & out_rdy;
    assign in_rdy = w_gnt;

    // First eligible requester at or after the pointer wins.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_gnt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && w_elig[f_rot(r_ptr, i)]) begin
                w_any  = 1'b1;
                w_gidx = f_rot(r_ptr, i);
            end
        end
        if (w_any) w_gnt[w_gidx] = 1'b1;
    end

    always_comb begin
        w_sel = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (w_gnt[r]) w_sel = in_data[r*DW +: DW];
        end
    end

    assign w_nxt = (w_gidx == IW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;

    // Tag pipe runs in lockstep with the stall-free reducer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            red_avail <= 1'b0;
            red_a     <= '0;
            r_tv      <= '0;
            r_tid     <= '0;
        end else begin
            red_avail <= w_any;
            red_a     <= w_sel;
            r_tv      <= {r_tv[RED_LAT-1:0], w_any};
            r_tid     <= {r_tid[RED_LAT-1:0], w_gidx};
            if (w_any) r_ptr <= w_nxt;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        logic [CW-1:0]    r_credit;
        logic [CW-1:0]    r_cnt;
        logic [PW-1:0]    r_wp;
        logic [PW-1:0]    r_rp;
        logic [MOD_W-1:0] r_mem [OUT_DEPTH];

        assign w_cok[g]   = (r_credit != '0);
        assign out_vld[g] = (r_cnt != '0);
        assign w_wr[g]    = r_tv[RED_LAT] && (r_tid[RED_LAT] == IW'(g));
        assign out_data[g*MOD_W +: MOD_W] = r_mem[r_rp];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_credit <= CW'(OUT_DEPTH);
                r_cnt    <= '0;
                r_wp     <= '0;
                r_rp     <= '0;
            end else begin
                if (w_gnt[g] && !w_pop[g])
                    r_credit <= r_credit - 1'b1;
                else if (!w_gnt[g] && w_pop[g])
                    r_credit <= r_credit + 1'b1;
                if (w_wr[g] && !w_pop[g])
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_wr[g] && w_pop[g])
                    r_cnt <= r_cnt - 1'b1;
                if (w_wr[g]) r_wp <= r_wp + 1'b1;
                if (w_pop[g]) r_rp <= r_rp + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr[g]) r_mem[r_wp] <= red_z;
        end

`ifdef MOD_REDUCT_GL_ARB_CHECK_EN
        a_no_ovf : assert property (@(posedge clk) disable iff (rst)
            (w_wr[g] && !w_pop[g]) |-> (r_cnt != CW'(OUT_DEPTH)));
        a_no_udf : assert property (@(posedge clk) disable iff (rst)
            w_gnt[g] |-> (r_credit != '0));
`endif
    end

`ifdef MOD_REDUCT_GL_ARB_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (r_tv[RED_LAT] != red_z_avail)
            r_err <= 1'b1;
    end

    assign err = r_err;

    a_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_rdy));
`else
    logic w_unused;
    assign w_unused = red_z_avail;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mod_reduct_gl_arb.sv
// Self-checking bench for mod_reduct_gl_arb with a behavioural reducer model.
// Table-driven single ops plus scoreboarded multi-cycle scenarios.
module tb_mod_reduct_gl_arb;
    localparam int N   = 4;
    localparam int MW  = 64;
    localparam int DW  = 2 * MW;
    localparam int LAT = 3;
    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;
`ifdef MOD_REDUCT_GL_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           in_vld;
    logic [N-1:0]           in_rdy;
    logic [N-1:0][DW-1:0]   in_data;
    logic                   red_avail;
    logic [DW-1:0]          red_a;
    logic                   red_z_avail;
    logic [MW-1:0]          red_z;
    logic [N-1:0]           out_vld;
    logic [N-1:0]           out_rdy;
    logic [N-1:0][MW-1:0]   out_data;
    logic                   err;
    logic                   inj;

    int n_checks = 0;
    int n_err    = 0;
    int seq      = 0;
    int acc_cnt [N];
    int pop_cnt [N];
    logic [MW-1:0] q [N][$];

    mod_reduct_gl_arb dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .red_avail(red_avail), .red_a(red_a),
        .red_z_avail(red_z_avail), .red_z(red_z),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] modp(input logic [DW-1:0] x);
        logic [DW-1:0] m;
        m = x % {64'h0, P};
        return m[MW-1:0];
    endfunction

    logic [LAT-1:0] m_v = '0;
    logic [MW-1:0]  m_z [LAT];
    always @(posedge clk) begin
        m_v    <= {m_v[LAT-2:0], red_avail};
        m_z[0] <= modp(red_a);
        for (int k = 1; k < LAT; k++) m_z[k] <= m_z[k-1];
    end
    assign red_z_avail = m_v[LAT-1] | inj;
    assign red_z       = m_z[LAT-1];

    task automatic check(input string nm, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) q[r].delete();
        end else begin
            check("rdy_onehot", DW'($onehot0(in_rdy)), 1);
            check("rdy_implies_vld", DW'(in_rdy & ~in_vld), 0);
            for (int r = 0; r < N; r++) begin
                if (in_vld[r] && in_rdy[r]) begin
                    q[r].push_back(modp(in_data[r]));
                    acc_cnt[r]++;
                end
                if (out_vld[r] && out_rdy[r]) begin
                    pop_cnt[r]++;
                    if (q[r].size() == 0) begin
                        check("sb_unexpected_out", DW'(out_data[r]), '1);
                    end else begin
                        check("sb_data", DW'(out_data[r]), DW'(q[r].pop_front()));
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int r);
        logic [DW-1:0] v;
        v = {64'h0, 32'(r), 32'(seq)};
        seq++;
        return v;
    endfunction

    task automatic run_cycles(input int n);
        logic [N-1:0] g;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            g = in_rdy;
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) if (g[r]) in_data[r] = mk(r);
        end
    endtask

    task automatic send_one(input int r, input logic [DW-1:0] d);
        bit got;
        @(posedge clk); #1;
        in_vld[r]  = 1'b1;
        in_data[r] = d;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_rdy[r]) begin
                got = 1;
                break;
            end
        end
        check("send_accept", DW'(got), 1);
        @(posedge clk); #1;
        in_vld[r] = 1'b0;
    endtask

    task automatic drain();
        in_vld  = '0;
        out_rdy = '1;
        repeat (12) @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) check("drain_empty", DW'(q[r].size()), 0);
    endtask

    typedef struct {
        int            r;
        logic [DW-1:0] a;
        logic [MW-1:0] z;
    } vec_t;

    localparam int NV = 6;
    vec_t tbl [NV];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] ev;
        logic [N-1:0] stale;
        int exp_idx, busy, base;

        tbl[0] = '{2, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
        tbl[1] = '{0, 128'h0, 64'h0};
        tbl[2] = '{1, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0006, 64'h5};
        tbl[3] = '{3, 128'h0000_0001_0000_0000_0000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000};
        tbl[4] = '{2, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFE};
        tbl[5] = '{0, {128{1'b1}}, 64'hFFFF_FFFE_0000_0000};

        rst = 1'b1; in_vld = '0; in_data = '0; out_rdy = '0; inj = 1'b0;
        for (int r = 0; r < N; r++) begin acc_cnt[r] = 0; pop_cnt[r] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_rdy", DW'(in_rdy), 0);
        check("rst_red_avail", DW'(red_avail), 0);
        check("rst_red_a", red_a, 0);
        check("rst_out_vld", DW'(out_vld), 0);
        check("rst_err", DW'(err), 0);

        out_rdy = '1;
        for (int i = 0; i < NV; i++) begin
            bit got;
            @(posedge clk); #1;
            in_vld[tbl[i].r]  = 1'b1;
            in_data[tbl[i].r] = tbl[i].a;
            got = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (in_rdy[tbl[i].r]) begin got = 1; break; end
            end
            check("vec_accept", DW'(got), 1);
            @(posedge clk); #1;
            in_vld[tbl[i].r] = 1'b0;
            @(negedge clk);
            check("vec_red_avail", DW'(red_avail), 1);
            check("vec_red_a", red_a, tbl[i].a);
            repeat (3) @(negedge clk);
            check("vec_early_vld", DW'(out_vld[tbl[i].r]), 0);
            @(negedge clk);
            check("vec_out_vld", DW'(out_vld[tbl[i].r]), 1);
            check("vec_out_data", DW'(out_data[tbl[i].r]), DW'(tbl[i].z));
        end
        drain();

        @(posedge clk); #1;
        in_vld = '1;
        for (int r = 0; r < N; r++) in_data[r] = mk(r);
        exp_idx = (tbl[NV-1].r + 1) % N;
        busy = 0;
        for (int c = 0; c <= 64; c++) begin
            @(negedge clk);
            g = in_rdy;
            if (c < 64) begin
                ev = N'(1) << exp_idx;
                check("rr_grant", DW'(g), DW'(ev));
                exp_idx = (exp_idx + 1) % N;
            end
            if (c > 0 && red_avail) busy++;
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) if (g[r]) in_data[r] = mk(r);
        end
        check("rr_util", DW'(busy), 64);
        drain();

        for (int r = 0; r < N; r++) acc_cnt[r] = 0;
        out_rdy = 4'b1101;
        in_vld  = '1;
        run_cycles(40);
        check("bp_accepts_r1", DW'(acc_cnt[1]), 4);
        check("bp_others_served", DW'(acc_cnt[0] >= 8 && acc_cnt[2] >= 8), 1);
        @(negedge clk);
        check("bp_rdy_r1_low", DW'(in_rdy[1]), 0);
        @(posedge clk); #1 out_rdy[1] = 1'b1;
        @(posedge clk); #1 out_rdy[1] = 1'b0;
        run_cycles(30);
        check("bp_one_more", DW'(acc_cnt[1]), 5);
        drain();

        base = pop_cnt[0];
        out_rdy = 4'b1110;
        send_one(0, 128'd10);
        send_one(0, 128'd11);
        send_one(0, 128'd12);
        repeat (8) @(posedge clk);
        #1;
        in_vld[0] = 1'b1; in_data[0] = 128'd13; out_rdy[0] = 1'b1;
        @(negedge clk);
        check("bnd_grant_pop", DW'(in_rdy[0]), 1);
        check("bnd_out_vld", DW'(out_vld[0]), 1);
        @(posedge clk); #1;
        in_data[0] = 128'd14; out_rdy[0] = 1'b0;
        @(negedge clk);
        check("bnd_last_credit", DW'(in_rdy[0]), 1);
        @(posedge clk); #1 in_vld[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 in_vld[0] = 1'b1; in_data[0] = 128'd15;
        @(negedge clk);
        check("bnd_full_no_rdy", DW'(in_rdy[0]), 0);
        @(posedge clk); #1 in_vld[0] = 1'b0;
        drain();
        check("bnd_pops", DW'(pop_cnt[0] - base), 5);

        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        @(negedge clk);
        check("err_next", DW'(err), DW'(EXP_ERR));
        repeat (5) @(negedge clk);
        check("err_sticky", DW'(err), DW'(EXP_ERR));
        check("err_no_out", DW'(out_vld), 0);

        out_rdy = 4'b0111;
        send_one(3, 128'd20);
        send_one(3, 128'd21);
        repeat (8) @(posedge clk);
        #1;
        in_vld = 4'b0111;
        for (int r = 0; r < 3; r++) in_data[r] = mk(r);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            g = in_rdy;
            @(posedge clk); #1;
            in_vld = in_vld & ~g;
        end
        check("rf_vld_all_taken", DW'(in_vld), 0);
        check("rf_buffered", DW'(out_vld[3]), 1);
        rst = 1'b1;
        #1;
        check("rf_out_vld_clr", DW'(out_vld), 0);
        check("rf_red_avail_clr", DW'(red_avail), 0);
        @(posedge clk); #1 rst = 1'b0;
        stale = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            stale = stale | out_vld;
        end
        check("rf_no_stale", DW'(stale), 0);
        acc_cnt[3] = 0;
        in_vld[3] = 1'b1;
        in_data[3] = mk(3);
        run_cycles(20);
        check("rf_credits", DW'(acc_cnt[3]), 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
